// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths, arbiter state encoding and sizing helpers
// used by rr_bus_arbiter and rr_picker.
package bus_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int BUS_MASK_W = 4;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Width of a counter that must be able to hold the value timeout_cycles.
   function automatic int wdog_width(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

   function automatic int idx_width(input int masters);
      return (masters > 1) ? $clog2(masters) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational rotating priority encoder. Returns the first
// requester at or after i_ptr, wrapping modulo MASTERS.
module rr_picker
   import bus_pkg::*;
#(
   parameter int MASTERS = 3,
   parameter int IDX_W   = 2
) (
   input  logic [MASTERS-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any_req
);

   int               w_cand;
   logic [IDX_W-1:0] w_cand_idx;

   // Walk offsets from farthest to nearest so the nearest requester wins.
   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      o_idx      = '0;
      w_cand     = 0;
      w_cand_idx = '0;
      for (int off = MASTERS - 1; off >= 0; off--) begin
         w_cand = int'(i_ptr) + off;
         if (w_cand >= MASTERS) w_cand = w_cand - MASTERS;
         w_cand_idx = IDX_W'(w_cand);
         if (i_req[w_cand_idx]) o_idx = w_cand_idx;
      end
   end

   assign o_any_req = |i_req;

endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin arbiter between bus masters and the slave fabric.
// Define BUS_TIMEOUT_EN to add the watchdog that faults hung transfers.
module rr_bus_arbiter
   import bus_pkg::*;
#(
   parameter int MASTERS        = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [MASTERS*BUS_ADDR_W-1:0]   m_address_in,
   input  logic [MASTERS-1:0]              m_read_in,
   input  logic [MASTERS-1:0]              m_write_in,
   input  logic [MASTERS*BUS_MASK_W-1:0]   m_write_mask_in,
   input  logic [MASTERS*BUS_DATA_W-1:0]   m_write_value_in,
   output logic [BUS_DATA_W-1:0]           m_read_value_out,
   output logic [MASTERS-1:0]              m_ready_out,
   output logic [MASTERS-1:0]              m_fault_out,
   output logic [BUS_ADDR_W-1:0]           address_out,
   output logic                            read_out,
   output logic                            write_out,
   output logic [BUS_MASK_W-1:0]           write_mask_out,
   output logic [BUS_DATA_W-1:0]           write_value_out,
   input  logic [BUS_DATA_W-1:0]           read_value_in,
   input  logic                            ready_in,
   input  logic                            fault_in
);

   localparam int IDX_W = idx_width(MASTERS);

   if (MASTERS < 2 || MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("rr_bus_arbiter: MASTERS must be 2..8 and TIMEOUT_CYCLES at least 1");
   end

   arb_state_t       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_grant, w_grant_nxt;
   logic [IDX_W-1:0] r_ptr,   w_ptr_nxt;

   logic [MASTERS-1:0]    w_req;
   logic [IDX_W-1:0]      w_pick_idx;
   logic                  w_any_req;
   logic                  w_granted;
   logic                  w_gnt_req;
   logic                  w_done;
   logic                  w_timeout;

   logic [BUS_ADDR_W-1:0] w_addr  [MASTERS];
   logic [BUS_MASK_W-1:0] w_mask  [MASTERS];
   logic [BUS_DATA_W-1:0] w_wdata [MASTERS];

   for (genvar gi = 0; gi < MASTERS; gi++) begin : g_unpack
      assign w_addr[gi]  = m_address_in[gi*BUS_ADDR_W +: BUS_ADDR_W];
      assign w_mask[gi]  = m_write_mask_in[gi*BUS_MASK_W +: BUS_MASK_W];
      assign w_wdata[gi] = m_write_value_in[gi*BUS_DATA_W +: BUS_DATA_W];
   end

   assign w_req = m_read_in | m_write_in;

   rr_picker #(
      .MASTERS (MASTERS),
      .IDX_W   (IDX_W)
   ) u_picker (
      .i_req     (w_req),
      .i_ptr     (r_ptr),
      .o_idx     (w_pick_idx),
      .o_any_req (w_any_req)
   );

   // Reset masks everything so a transfer cut short by reset never strobes.
   assign w_granted = (r_state == ARB_GRANT) && !reset;
   assign w_gnt_req = w_req[r_grant];
   assign w_done    = w_granted && w_gnt_req && (ready_in || fault_in);

`ifdef BUS_TIMEOUT_EN
   localparam int WD_W = wdog_width(TIMEOUT_CYCLES);

   logic [WD_W-1:0] r_wdog;

   // Held at zero outside GRANT, so it starts from zero on every grant entry.
   always_ff @(posedge clk) begin
      if (reset || r_state != ARB_GRANT) r_wdog <= '0;
      else                               r_wdog <= r_wdog + 1'b1;
   end

   // r_wdog counts completed GRANT cycles; the current one is the TIMEOUT_CYCLES-th.
   assign w_timeout = w_granted && w_gnt_req && !(ready_in || fault_in) &&
                      (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      address_out      = '0;
      read_out         = 1'b0;
      write_out        = 1'b0;
      write_mask_out   = '0;
      write_value_out  = '0;
      m_ready_out      = '0;
      m_fault_out      = '0;
      m_read_value_out = '0;
      if (w_granted) begin
         address_out     = w_addr[r_grant];
         read_out        = m_read_in[r_grant];
         write_out       = m_write_in[r_grant];
         write_mask_out  = w_mask[r_grant];
         write_value_out = w_wdata[r_grant];
      end
      if (w_done) begin
         m_ready_out[r_grant] = 1'b1;
         m_fault_out[r_grant] = fault_in;
         m_read_value_out     = read_value_in;
      end else if (w_timeout) begin
         m_ready_out[r_grant] = 1'b1;
         m_fault_out[r_grant] = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         ARB_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = ARB_GRANT;
               w_grant_nxt = w_pick_idx;
            end
         end
         ARB_GRANT: begin
            // A master withdrawing its request aborts without moving the pointer.
            if (!w_gnt_req) begin
               w_state_nxt = ARB_IDLE;
            end else if (w_done || w_timeout) begin
               w_state_nxt = ARB_IDLE;
               w_ptr_nxt   = (r_grant == IDX_W'(MASTERS - 1)) ? '0 : r_grant + 1'b1;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ARB_IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level reference model of the arbiter.
module tb_rr_bus_arbiter;

   localparam int M  = 3;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [M*32-1:0]   m_address_in;
   logic [M-1:0]      m_read_in;
   logic [M-1:0]      m_write_in;
   logic [M*4-1:0]    m_write_mask_in;
   logic [M*32-1:0]   m_write_value_in;
   logic [31:0]       m_read_value_out;
   logic [M-1:0]      m_ready_out;
   logic [M-1:0]      m_fault_out;
   logic [31:0]       address_out;
   logic              read_out;
   logic              write_out;
   logic [3:0]        write_mask_out;
   logic [31:0]       write_value_out;
   logic [31:0]       read_value_in;
   logic              ready_in;
   logic              fault_in;

   rr_bus_arbiter #(
      .MASTERS        (M),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .m_address_in     (m_address_in),
      .m_read_in        (m_read_in),
      .m_write_in       (m_write_in),
      .m_write_mask_in  (m_write_mask_in),
      .m_write_value_in (m_write_value_in),
      .m_read_value_out (m_read_value_out),
      .m_ready_out      (m_ready_out),
      .m_fault_out      (m_fault_out),
      .address_out      (address_out),
      .read_out         (read_out),
      .write_out        (write_out),
      .write_mask_out   (write_mask_out),
      .write_value_out  (write_value_out),
      .read_value_in    (read_value_in),
      .ready_in         (ready_in),
      .fault_in         (fault_in)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cycle  = 0;

   // Reference model: who owns the bus, where round-robin resumes, how long
   // the current transfer has been running, and the slave latency chosen for it.
   bit mb_busy  = 1'b0;
   int mb_owner = 0;
   int mb_ptr   = 0;
   int mb_age   = 0;
   int mb_lat   = 0;
   int strobe_idx;

   int          dut_log[$];
   logic [M-1:0] last_rdy;
   logic [M-1:0] last_flt;
   logic [31:0]  last_rv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n_cycle, obs, exp);
      end
   endtask

   // Compare one cycle of DUT outputs with the model, then advance both by a clock.
   task automatic step();
      logic [31:0]  e_addr, e_wval, e_rv;
      logic         e_rd, e_wr;
      logic [3:0]   e_mask;
      logic [M-1:0] e_rdy, e_flt;
      bit           owner_req, done, found;
      #1;
      e_addr = '0; e_wval = '0; e_rv = '0; e_rd = 1'b0; e_wr = 1'b0;
      e_mask = '0; e_rdy = '0; e_flt = '0;
      done = 1'b0;
      strobe_idx = -1;
      owner_req = m_read_in[mb_owner] | m_write_in[mb_owner];
      if (!reset && mb_busy) begin
         e_addr = m_address_in[32*mb_owner +: 32];
         e_rd   = m_read_in[mb_owner];
         e_wr   = m_write_in[mb_owner];
         e_mask = m_write_mask_in[4*mb_owner +: 4];
         e_wval = m_write_value_in[32*mb_owner +: 32];
         if (owner_req) begin
            if (ready_in || fault_in) begin
               e_rdy[mb_owner] = 1'b1;
               e_flt[mb_owner] = fault_in;
               e_rv = read_value_in;
               done = 1'b1;
            end
`ifdef BUS_TIMEOUT_EN
            else if (mb_age + 1 == TO) begin
               e_rdy[mb_owner] = 1'b1;
               e_flt[mb_owner] = 1'b1;
               done = 1'b1;
            end
`endif
         end
      end
      check("address_out",      address_out,      e_addr);
      check("read_out",         32'(read_out),    32'(e_rd));
      check("write_out",        32'(write_out),   32'(e_wr));
      check("write_mask_out",   32'(write_mask_out), 32'(e_mask));
      check("write_value_out",  write_value_out,  e_wval);
      check("m_ready_out",      32'(m_ready_out), 32'(e_rdy));
      check("m_fault_out",      32'(m_fault_out), 32'(e_flt));
      check("m_read_value_out", m_read_value_out, e_rv);
      if (m_ready_out != '0) begin
         found = 1'b0;
         for (int i = 0; i < M; i++)
            if (m_ready_out[i] && !found) begin
               dut_log.push_back(i);
               found = 1'b1;
            end
         last_rdy = m_ready_out;
         last_flt = m_fault_out;
         last_rv  = m_read_value_out;
      end
      if (reset) begin
         mb_busy = 1'b0;
         mb_ptr  = 0;
      end else if (mb_busy) begin
         if (!owner_req) begin
            mb_busy = 1'b0;
         end else if (done) begin
            mb_busy = 1'b0;
            strobe_idx = mb_owner;
            mb_ptr = (mb_owner + 1) % M;
         end else begin
            mb_age++;
         end
      end else if ((m_read_in | m_write_in) != '0) begin
         found = 1'b0;
         for (int k = 0; k < M; k++)
            if (!found && (m_read_in[(mb_ptr + k) % M] | m_write_in[(mb_ptr + k) % M])) begin
               mb_owner = (mb_ptr + k) % M;
               found = 1'b1;
            end
         mb_busy = 1'b1;
         mb_age  = 0;
         mb_lat  = $urandom_range(0, 3);
      end
      @(posedge clk);
      @(negedge clk);
      n_cycle++;
   endtask

   initial begin
      int   base;
      int   kind;
      logic w_sel;

      reset = 1'b1;
      m_address_in = '0; m_read_in = '0; m_write_in = '0;
      m_write_mask_in = '0; m_write_value_in = '0;
      read_value_in = '0; ready_in = 1'b0; fault_in = 1'b0;
      @(negedge clk);

      // 1: reset for 3 cycles, then all masters read from a zero-wait slave.
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < M; i++) begin
         m_address_in[32*i +: 32]     = 32'h1000 * (i + 1);
         m_write_value_in[32*i +: 32] = 32'hC0DE_0000 + i;
      end
      m_read_in = 3'b111;
      ready_in = 1'b1;
      read_value_in = 32'h1234_5678;
      dut_log.delete();
      repeat (8) step();
      check("t1_count", dut_log.size(), 4);
      if (dut_log.size() == 4) begin
         check("t1_grant0", dut_log[0], 0);
         check("t1_grant1", dut_log[1], 1);
         check("t1_grant2", dut_log[2], 2);
         check("t1_grant3", dut_log[3], 0);
      end
      m_read_in = '0;
      ready_in = 1'b0;
      step();

      // 2: master 1 write, slave ready on the third GRANT cycle.
      m_address_in[32 +: 32]     = 32'h0001_0000;
      m_write_mask_in[4 +: 4]    = 4'b0001;
      m_write_value_in[32 +: 32] = 32'h0000_00A5;
      m_write_in = 3'b010;
      repeat (3) step();
      ready_in = 1'b1;
      step();
      check("t2_ready", 32'(last_rdy), 32'(3'b010));
      check("t2_fault", 32'(last_flt), 32'(3'b000));
      m_write_in = '0;
      ready_in = 1'b0;
      step();

      // 3: master 2 reads an unmapped address; decode fault completes at once.
      m_address_in[64 +: 32] = 32'h0004_0000;
      m_read_in = 3'b100;
      fault_in = 1'b1;
      read_value_in = 32'h0;
      repeat (2) step();
      check("t3_ready", 32'(last_rdy), 32'(3'b100));
      check("t3_fault", 32'(last_flt), 32'(3'b100));
      m_read_in = '0;
      fault_in = 1'b0;
      step();

`ifdef BUS_TIMEOUT_EN
      // 4: master 0 reads a silent slave; watchdog fires on the TO-th GRANT cycle.
      m_read_in = 3'b001;
      read_value_in = 32'hDEAD_BEEF;
      step();
      repeat (2) step();
      m_read_in[1] = 1'b1;
      repeat (TO - 2) step();
      check("t4_ready", 32'(last_rdy), 32'(3'b001));
      check("t4_fault", 32'(last_flt), 32'(3'b001));
      check("t4_rv", last_rv, 32'h0);
      m_read_in[0] = 1'b0;
      ready_in = 1'b1;
      repeat (2) step();
      check("t4_next", dut_log[$], 1);
      m_read_in = '0;
      ready_in = 1'b0;
      step();
`endif

      // 5: reset lands mid-GRANT of master 0; master 0 wins again after release.
      m_read_in = 3'b001;
      repeat (3) step();
      reset = 1'b1;
      m_read_in = 3'b011;
      step();
      reset = 1'b0;
      base = dut_log.size();
      step();
      ready_in = 1'b1;
      step();
      check("t5_count", dut_log.size(), base + 1);
      check("t5_first", dut_log[$], 0);

      // 6: master 1 withdraws mid-GRANT; pending master 2 is granted next.
      m_read_in = 3'b110;
      ready_in = 1'b0;
      repeat (2) step();
      m_read_in[1] = 1'b0;
      step();
      step();
      ready_in = 1'b1;
      step();
      check("t6_count", dut_log.size(), base + 2);
      check("t6_next", dut_log[$], 2);
      m_read_in = '0;
      ready_in = 1'b0;
      step();

      // Randomized traffic: masters hold requests until served, slave latency 0..3.
      for (int c = 0; c < 800; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < M; i++) begin
            if (!(m_read_in[i] | m_write_in[i])) begin
               if ($urandom_range(0, 3) == 0) begin
                  w_sel = 1'($urandom_range(0, 1));
                  m_read_in[i]  = !w_sel;
                  m_write_in[i] = w_sel;
                  m_address_in[32*i +: 32]     = $urandom;
                  m_write_mask_in[4*i +: 4]    = 4'($urandom);
                  m_write_value_in[32*i +: 32] = $urandom;
               end
            end else if (mb_busy && mb_owner == i && $urandom_range(0, 39) == 0) begin
               m_read_in[i]  = 1'b0;
               m_write_in[i] = 1'b0;
            end
         end
         if (mb_busy && mb_age >= mb_lat) begin
            kind = $urandom_range(0, 5);
            ready_in = (kind != 0);
            fault_in = (kind <= 1);
         end else begin
            ready_in = (!mb_busy && $urandom_range(0, 1) == 1);
            fault_in = (!mb_busy && $urandom_range(0, 3) == 0);
         end
         read_value_in = $urandom;
         step();
         if (strobe_idx >= 0) begin
            m_read_in[strobe_idx]  = 1'b0;
            m_write_in[strobe_idx] = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
